// File: rtl/ptos_tx.sv
// Parallel-to-serial SPI transmit stage: MSB-first shift with per-bit sen strobe,
// frame select, and a one-entry holding register for back-to-back frames.
module ptos_tx #(
    parameter int WIDTH = 10,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sen,
    output logic             cs_n,
    output logic             busy,
    output logic             done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [DW-1:0]    div_q, div_d;
    logic             sout_q, sout_d;
    logic             sen_q, sen_d;
    logic             cs_n_q, cs_n_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic accept;
    logic bit_end;
    logic shifting;

    assign din_ready = !hold_full_q;
    assign accept    = din_valid && !hold_full_q;
    // With DIV=1 every cycle closes a bit period; div_q stays at zero.
    assign bit_end   = (DIV == 1) || (div_q == DW'(DIV - 1));

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_d       = bit_q;
        div_d       = div_q;
        case (state_q)
            IDLE: begin
                bit_d = '0;
                div_d = '0;
                if (hold_full_q) begin
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end else if (din_valid) begin
                    shreg_d = din;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (accept) begin
                    hold_d      = din;
                    hold_full_d = 1'b1;
                end
                if (bit_end) begin
                    div_d   = '0;
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    if (bit_q == BW'(WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = GAP;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    div_d = div_q + DW'(1);
                end
            end
            GAP: begin
                // Decision uses hold_full before this edge; a word accepted now starts via IDLE.
                if (hold_full_q) begin
                    shreg_d     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = SHIFT;
                end else begin
                    state_d = IDLE;
                end
                if (accept) begin
                    hold_d      = din;
                    hold_full_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with the state.
    always_comb begin
        shifting = (state_d == SHIFT);
        sout_d   = shifting && shreg_d[WIDTH-1];
        sen_d    = shifting && (div_d == '0);
        cs_n_d   = !shifting;
        done_d   = (state_d == GAP);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_q       <= '0;
            div_q       <= '0;
            sout_q      <= 1'b0;
            sen_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_q       <= bit_d;
            div_q       <= div_d;
            sout_q      <= sout_d;
            sen_q       <= sen_d;
            cs_n_q      <= cs_n_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sout = sout_q;
    assign sen  = sen_q;
    assign cs_n = cs_n_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_ptos_tx.sv
// Bench for ptos_tx: frame-position reference model with a hold queue, directed
// scenarios, random traffic, and a DIV=1 loopback into a simple deserializer.
module tb_ptos_tx;

    localparam int W = 10;
    localparam int D = 4;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] din_a, din_b;
    logic         dv_a, dv_b;
    logic         rdy_a, sout_a, sen_a, cs_a, busy_a, done_a;
    logic         rdy_b, sout_b, sen_b, cs_b, busy_b, done_b;

    int total = 0;
    int bad   = 0;

    // Reference model: pos = cycle index inside the current frame, -1 when idle.
    // 0..W*D-1 are shift cycles, W*D is the gap cycle.
    int           pos;
    logic [W-1:0] cur;
    logic [W-1:0] hq[$];

    logic [W-1:0] des;

    ptos_tx #(.WIDTH(W), .DIV(D)) u_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .din_valid(dv_a), .din_ready(rdy_a),
        .sout(sout_a), .sen(sen_a), .cs_n(cs_a), .busy(busy_a), .done(done_a)
    );

    ptos_tx #(.WIDTH(W), .DIV(1)) u_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .din_valid(dv_b), .din_ready(rdy_b),
        .sout(sout_b), .sen(sen_b), .cs_n(cs_b), .busy(busy_b), .done(done_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream deserializer: samples sout on each sen strobe.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) des <= '0;
        else if (sen_b) des <= {des[W-2:0], sout_b};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // {sout, sen, cs_n, done, busy, din_ready}
    function automatic logic [5:0] model_outs();
        logic sh, so, se;
        sh = (pos >= 0) && (pos < W * D);
        so = sh ? cur[W - 1 - pos / D] : 1'b0;
        se = sh && (pos % D == 0);
        return {so, se, !sh, pos == W * D, pos >= 0, hq.size() == 0};
    endfunction

    task automatic check_a(input string tag);
        chk(tag, {26'd0, sout_a, sen_a, cs_a, done_a, busy_a, rdy_a}, {26'd0, model_outs()});
    endtask

    task automatic model_edge(input logic v, input logic [W-1:0] d);
        logic acc, had;
        acc = v && (hq.size() == 0);
        if (pos < 0) begin
            if (hq.size() != 0) begin cur = hq.pop_front(); pos = 0; end
            else if (v) begin cur = d; pos = 0; end
        end else if (pos < W * D) begin
            pos++;
            if (acc) hq.push_back(d);
        end else begin
            had = (hq.size() != 0);
            if (had) begin cur = hq.pop_front(); pos = 0; end
            else pos = -1;
            if (acc) hq.push_back(d);
        end
    endtask

    task automatic model_reset();
        pos = -1;
        hq.delete();
    endtask

    // Drive at negedge, advance one clock, check at the following negedge.
    task automatic step(input logic v, input logic [W-1:0] d, input string tag);
        dv_a  = v;
        din_a = d;
        @(posedge clk);
        model_edge(v, d);
        @(negedge clk);
        check_a(tag);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 3 * W * D && (pos >= 0 || hq.size() != 0); i++) step(1'b0, '0, tag);
        chk({tag, "_idle"}, {31'd0, busy_a}, 32'd0);
    endtask

    initial begin
        int run, best;
        logic seen;
        rst_n = 1'b0;
        dv_a  = 1'b0; din_a = '0;
        dv_b  = 1'b0; din_b = '0;
        model_reset();
        cur = '0;

        // Reset held with din_valid toggling
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dv_a  = ~dv_a;
            din_a = W'($urandom);
            #1 check_a("reset_hold");
        end
        @(negedge clk);
        dv_a  = 1'b0;
        rst_n = 1'b1;
        check_a("reset_release");
        for (int i = 0; i < 3; i++) step(1'b0, '0, "idle_after_reset");

        // Single frame
        step(1'b1, 10'b1011001110, "single");
        for (int i = 0; i < W * D + 1; i++) step(1'b0, '0, "single");
        drain("single");

        // Queueing: B presented during A's bit 3, C held off until B starts
        step(1'b1, 10'h3FF, "queue_a");
        for (int i = 0; i < 3 * D; i++) step(1'b0, '0, "queue_a");
        step(1'b1, 10'h155, "queue_b");
        chk("queue_b_held", {31'd0, rdy_a}, 32'd0);
        for (int i = 0; i < 3 * W * D && hq.size() != 0; i++) step(1'b1, 10'h0AA, "queue_c");
        step(1'b1, 10'h0AA, "queue_c_acc");
        drain("queue");

        // Word presented only in the gap cycle
        step(1'b1, 10'h2F0, "gap_a");
        for (int i = 0; i < W * D; i++) step(1'b0, '0, "gap_a");
        chk("gap_done", {31'd0, done_a}, 32'd1);
        step(1'b1, 10'h10F, "gap_acc");
        chk("gap_then_idle", {30'd0, cs_a, busy_a}, 32'd2);
        drain("gap");

        // Reset abort during bit 4 with hold full
        step(1'b1, 10'h3C3, "abort_a");
        for (int i = 0; i < 4 * D; i++) step(1'b0, '0, "abort_a");
        step(1'b1, 10'h0F0, "abort_hold");
        chk("abort_hold_full", {31'd0, rdy_a}, 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("abort_async", {26'd0, sout_a, sen_a, cs_a, done_a, busy_a, rdy_a}, 32'h09);
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check_a("abort_in_reset");
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b0, '0, "abort_no_restart");
        step(1'b1, 10'h2A5, "abort_next");
        drain("abort_next");

        // Random traffic
        for (int i = 0; i < 2000; i++)
            step(($urandom_range(0, 99) < 30), W'($urandom), "rand");
        drain("rand");

        // Loopback at DIV=1
        @(negedge clk);
        dv_b  = 1'b1;
        din_b = 10'h2A5;
        @(negedge clk);
        dv_b = 1'b0;
        run = 0; best = 0; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (sen_b) begin
                run++;
                if (run > best) best = run;
            end else run = 0;
            if (done_b) seen = 1'b1;
            else @(negedge clk);
        end
        chk("lb_done_seen", {31'd0, seen}, 32'd1);
        chk("lb_sen_run", best, 32'd10);
        chk("lb_word", {22'd0, des}, 32'h2A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ptos_tx.md
# ptos_tx

Parallel-to-serial SPI transmit stage. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first on `sout`. It also produces a one-cycle `sen` strobe per bit, so the receive-side serial-to-parallel deserializer can sample `in` directly on `clk`. It sits directly upstream of that deserializer: `sout`→`in`, `sen`→`enable`. A one-entry holding register allows a second word to be queued while a frame is in flight.

## Interface
- WIDTH, 10, bits per frame (≥2)
- DIV, 4, `clk` cycles per serial bit (≥1)

- clk  input  1  system clock; all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- din  input  WIDTH  word to transmit
- din_valid  input  1  `din` valid
- din_ready  output  1  block can accept `din` this cycle
- sout  output  1  serial data, MSB first
- sen  output  1  one-cycle strobe marking each valid bit (drives downstream `enable`)
- cs_n  output  1  frame select, low while a frame's bits are on `sout`
- busy  output  1  high in SHIFT or GAP
- done  output  1  one-cycle pulse after the last bit of a frame

## Operation
- Registers:
  - `shreg` [WIDTH]
  - `hold` [WIDTH] plus `hold_full`
  - bit counter, $clog2(WIDTH) bits
  - divider counter, $clog2(DIV) bits (omitted when DIV=1)
  - state
- States: IDLE, SHIFT, GAP.
- **IDLE**
  - `din_ready` = !hold_full.
  - If hold_full: load `hold` into `shreg`, clear hold_full, go to SHIFT.
  - Else, if din_valid: load `din` into `shreg`, go to SHIFT.
- **SHIFT**
  - `sout` = `shreg[WIDTH-1]`; cs_n=0.
  - Each bit occupies DIV cycles. `sen`=1 only in the first cycle of each bit period.
  - At the end of each bit period, `shreg` shifts left by 1 and the bit counter increments.
  - After bit WIDTH-1's period completes, go to GAP.
  - `din_ready` = !hold_full. A handshake (din_valid && din_ready) writes `hold` and sets hold_full.
- **GAP** (exactly 1 cycle)
  - cs_n=1, sen=0, done=1.
  - `din_ready` = !hold_full; an accepted word goes to `hold`.
  - Next state uses hold_full as registered before the edge: if 1, load `hold` into `shreg`, clear it, and go to SHIFT; else go to IDLE.
  - A word accepted during GAP is therefore started from IDLE one cycle later.
- `sout` is 0 whenever not in SHIFT. `busy` = (state != IDLE).
- A handshake and a hold drain in the same cycle cannot occur: `din_ready` is low whenever hold_full.
- `din` is ignored when din_valid=0; din_valid with din_ready=0 has no effect (upstream holds).

## Timing
- Reset values (asynchronous, while rst_n=0):
  - Registered: state=IDLE, hold_full=0, shreg=0, counters=0, sout=0, sen=0, cs_n=1, done=0, busy=0.
  - Combinational: din_ready=1.
- Accept at edge T (IDLE): first SHIFT cycle is T+1.
  - Bit k (k=0 is MSB) is on `sout` during cycles T+1+k·DIV … T+(k+1)·DIV.
  - `sen` is high at cycle T+1+k·DIV.
- cs_n is low for exactly WIDTH·DIV cycles.
- GAP is at cycle T+1+WIDTH·DIV, with done=1 there.
- Back-to-back (hold full before GAP): the next frame's MSB appears at GAP+1, giving exactly one cs_n-high cycle between frames.
- Reset mid-frame:
  - cs_n rises and sen/sout drop immediately (asynchronously).
  - The frame is aborted, hold is discarded, and no done pulse is produced.
- DIV=1: sen is high every SHIFT cycle.

## Test plan
- Reset check: hold rst_n=0 for 3 cycles with din_valid toggling.
  - Required: cs_n=1, sen=0, sout=0, done=0, busy=0, din_ready=1 throughout; no frame starts after release until a handshake.
- Single frame, WIDTH=10, DIV=4, din=10'b1011001110 accepted at T.
  - Required: sen pulses at T+1, T+5, …, T+37; `sout` at those cycles reads 1,0,1,1,0,0,1,1,1,0.
  - Required: cs_n low T+1..T+40; done=1 only at T+41; IDLE at T+42.
- Queueing: frame A (10'h3FF) starts; frame B (10'h155) is presented at A's bit 3.
  - Required: B accepted immediately and din_ready=0 until GAP.
  - Required: B's MSB on `sout` at A-GAP+1; a third word C is held off until B's SHIFT begins.
- GAP acceptance: a word is presented only in A's GAP cycle.
  - Required: accepted; one IDLE cycle follows (cs_n=1 for 2 cycles); then the frame starts.
- Reset abort, DIV=4: assert rst_n=0 during bit 4 with hold full.
  - Required: cs_n=1 in the same cycle, no done pulse, hold discarded.
  - Required: the next accepted word 10'h2A5 transmits correctly from MSB.
- Loopback, DIV=1: connect to the downstream deserializer (WIDTH=10) and send 10'h2A5.
  - Required: 10 consecutive sen cycles; the deserializer output equals 10'h2A5 after its finish.
